ram_stream_reader: RTL and testbench
====================================

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 8, RAM word width in bits.
REQ-002 SHALL have parameter ADDRWIDTH, default 10, RAM address width (1024 words).
REQ-003 SHALL have port Clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port RstN_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port Start_i  input  1  begin a read burst (sampled only in IDLE).
REQ-006 SHALL have port BaseAddr_i  input  ADDRWIDTH  first RAM address of burst.
REQ-007 SHALL have port Len_i  input  ADDRWIDTH+1  word count, 0..1024.
REQ-008 SHALL have port RAM_REn_o  output  1  RAM read enable.
REQ-009 SHALL have port RAM_Addr_o  output  ADDRWIDTH  RAM read address.
REQ-010 SHALL have port RAM_Data_i  input  DATAWIDTH  RAM read data, valid exactly 1 cycle after RAM_REn_o.
REQ-011 SHALL have port Data_o  output  DATAWIDTH  stream data.
REQ-012 SHALL have port Valid_o  output  1  stream data valid.
REQ-013 SHALL have port Ready_i  input  1  downstream accepts when Valid_o && Ready_i.
REQ-014 SHALL have port Last_o  output  1  marks final word of burst, qualified by Valid_o.
REQ-015 SHALL have port Busy_o  output  1  high in any state other than IDLE.
REQ-016 SHALL have port Done_o  output  1  one-cycle pulse at burst completion.

Function
REQ-017 SHALL implement states IDLE, READ, DRAIN.
REQ-018 IDLE -> READ when Start_i=1 and Len_i>0; latch BaseAddr_i into address counter, Len_i into issue and return counters.
REQ-019 IDLE with Start_i=1 and Len_i=0 SHALL stay IDLE, issue no reads, and pulse Done_o the following cycle.
REQ-020 Start_i outside IDLE SHALL be ignored; no latching, no effect on the running burst.
REQ-021 In READ, a read SHALL issue (RAM_REn_o=1) only when words-in-flight plus buffer occupancy < 2; address increments by 1 per issue, wrapping 1023 -> 0.
REQ-022 READ -> DRAIN in the cycle after the last read issues; DRAIN -> IDLE on handshake of the Last_o word.
REQ-023 RAM_Data_i SHALL be captured into a 2-entry FIFO one cycle after each issued read; order preserved.
REQ-024 Valid_o SHALL equal FIFO non-empty; Data_o is FIFO head; Data_o/Last_o SHALL hold stable while Valid_o=1 and Ready_i=0.
REQ-025 Simultaneous FIFO write and pop SHALL be supported in the same cycle; FIFO SHALL never overflow (guaranteed by REQ-021).
REQ-026 With Ready_i held 1, sustained throughput SHALL be 1 word/cycle; first Valid_o rises 2 cycles after Start_i accepted.
REQ-027 Last_o SHALL be 1 only on the word whose return counter equals 1.
REQ-028 Done_o SHALL pulse in the cycle after the Last_o handshake; Busy_o falls in that same cycle.
REQ-029 RAM_Addr_o SHALL hold its last value when RAM_REn_o=0.

Reset
REQ-030 RstN_i=0 SHALL immediately force state IDLE, FIFO empty, counters 0, RAM_Addr_o=0.
REQ-031 Under reset: RAM_REn_o=0, Valid_o=0, Last_o=0, Busy_o=0, Done_o=0, Data_o=0.
REQ-032 Reset mid-burst SHALL abandon the burst with no Done_o pulse; in-flight RAM data after reset release SHALL be discarded.

Structure
REQ-033 ADDRWIDTH/DATAWIDTH defaults and the state encoding (IDLE=0, READ=1, DRAIN=2) SHALL live in the shared RAM package used by RAM and this block.
REQ-034 The 2-entry FIFO SHALL be a sub-module named skid_fifo2 (parameter DATAWIDTH, carries data plus last flag).

Verification
REQ-035 RAM preloaded with mem[i]=i[7:0]; Start, BaseAddr=0, Len=16, Ready=1 -> Data_o 0..15 on 16 consecutive cycles, Last_o on 15, Done_o one cycle later.
REQ-036 BaseAddr=1020, Len=8 -> Data_o 252,253,254,255,0,1,2,3 (addresses wrap 1023->0).
REQ-037 Len=16, Ready toggled 1/0 each cycle -> no word lost or duplicated, Data_o stable during stalls, RAM_REn_o never issues with 2 words pending.
REQ-038 Len=0 -> no RAM_REn_o, no Valid_o, Done_o pulse one cycle after Start_i.
REQ-039 Start during burst (Len=4, second Start at cycle 2 with BaseAddr=500) -> ignored, 4 words from original base only.
REQ-040 RstN_i low at word 5 of Len=10 -> all outputs 0 immediately, no Done_o; new Start after release with Len=3 returns 3 correct words.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// Shared RAM geometry defaults and the burst reader state encoding.
// Pure declarations; no logic, no latency, no flow control.
package ram_stream_reader_pkg;

   localparam int DATAWIDTH_DEF = 8;
   localparam int ADDRWIDTH_DEF = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

endpackage

// File: rtl/skid_fifo2.sv
// Two-entry FIFO of {last, data}; registered output, push-to-valid latency 1 cycle.
// Push and pop may coincide; a push into a full FIFO without a pop is dropped (caller must not do that).
module skid_fifo2 #(
   parameter int DATAWIDTH = 8
) (
   input  logic                 core_clk,
   input  logic                 arst_n,
   input  logic                 wr_vld,
   input  logic [DATAWIDTH-1:0] wr_dat,
   input  logic                 wr_last,
   input  logic                 rd_rdy,
   output logic                 rd_vld,
   output logic [DATAWIDTH-1:0] rd_dat,
   output logic                 rd_last,
   output logic [1:0]           count
);

   logic [1:0][DATAWIDTH:0] mem_q;
   logic                    wr_ptr_q;
   logic                    rd_ptr_q;
   logic [1:0]              cnt_q;
   logic                    push;
   logic                    pop;

   assign rd_vld  = (cnt_q != 2'd0);
   assign pop     = rd_vld & rd_rdy;
   assign push    = wr_vld & ((cnt_q != 2'd2) | pop);
   assign rd_dat  = mem_q[rd_ptr_q][DATAWIDTH-1:0];
   assign rd_last = mem_q[rd_ptr_q][DATAWIDTH];
   assign count   = cnt_q;

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         mem_q    <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= {wr_last, wr_dat};
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         cnt_q <= cnt_q + 2'(push) - 2'(pop);
      end
   end

endmodule

// File: rtl/ram_stream_reader.sv
// Reads Len_i consecutive RAM words (address wraps) into a valid/ready stream; first Valid_o 2 cycles after Start_i.
// Issue is throttled so in-flight reads plus buffered words never exceed 2; stalls hold Data_o/Last_o.
module ram_stream_reader
   import ram_stream_reader_pkg::*;
#(
   parameter int DATAWIDTH = DATAWIDTH_DEF,
   parameter int ADDRWIDTH = ADDRWIDTH_DEF
) (
   input  logic                 Clk_i,
   input  logic                 RstN_i,
   input  logic                 Start_i,
   input  logic [ADDRWIDTH-1:0] BaseAddr_i,
   input  logic [ADDRWIDTH:0]   Len_i,
   output logic                 RAM_REn_o,
   output logic [ADDRWIDTH-1:0] RAM_Addr_o,
   input  logic [DATAWIDTH-1:0] RAM_Data_i,
   output logic [DATAWIDTH-1:0] Data_o,
   output logic                 Valid_o,
   input  logic                 Ready_i,
   output logic                 Last_o,
   output logic                 Busy_o,
   output logic                 Done_o
);

   localparam logic [ADDRWIDTH-1:0] ADDR_ONE = {{(ADDRWIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDRWIDTH:0]   CNT_ONE  = {{ADDRWIDTH{1'b0}}, 1'b1};

   rd_state_t              state_q, state_d;
   logic [ADDRWIDTH-1:0]   addr_q;
   logic [ADDRWIDTH-1:0]   addr_out_q;
   logic [ADDRWIDTH:0]     issue_cnt_q;
   logic [ADDRWIDTH:0]     ret_cnt_q;
   logic                   inflight_q;
   logic                   done_q;

   logic                   issue;
   logic                   done_d;
   logic                   start_ok;
   logic                   start_zero;
   logic                   pop;
   logic                   last_hs;
   logic [1:0]             occ_nxt;
   logic                   fifo_vld;
   logic                   fifo_last;
   logic [DATAWIDTH-1:0]   fifo_dat;
   logic [1:0]             fifo_cnt;

   assign start_ok   = (state_q == IDLE) && Start_i && (Len_i != '0);
   assign start_zero = (state_q == IDLE) && Start_i && (Len_i == '0);
   assign pop        = fifo_vld & Ready_i;
   assign last_hs    = pop & fifo_last;
   // Counting the word leaving this cycle keeps one read per cycle flowing under Ready_i=1.
   assign occ_nxt    = fifo_cnt + 2'(inflight_q) - 2'(pop);

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            done_d = start_zero;
            if (start_ok) begin
               state_d = READ;
            end
         end
         READ: begin
            issue = (issue_cnt_q != '0) && (occ_nxt < 2'd2);
            if (issue && (issue_cnt_q == CNT_ONE)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (last_hs) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk_i or negedge RstN_i) begin
      if (!RstN_i) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         addr_out_q  <= '0;
         issue_cnt_q <= '0;
         ret_cnt_q   <= '0;
         inflight_q  <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         inflight_q <= issue;
         done_q     <= done_d;
         if (start_ok) begin
            addr_q      <= BaseAddr_i;
            issue_cnt_q <= Len_i;
            ret_cnt_q   <= Len_i;
         end else begin
            if (issue) begin
               addr_q      <= addr_q + ADDR_ONE;
               addr_out_q  <= addr_q;
               issue_cnt_q <= issue_cnt_q - CNT_ONE;
            end
            if (inflight_q) begin
               ret_cnt_q <= ret_cnt_q - CNT_ONE;
            end
         end
      end
   end

   // Read data is only accepted for reads issued since the last reset.
   skid_fifo2 #(
      .DATAWIDTH (DATAWIDTH)
   ) u_fifo (
      .core_clk (Clk_i),
      .arst_n   (RstN_i),
      .wr_vld   (inflight_q),
      .wr_dat   (RAM_Data_i),
      .wr_last  (ret_cnt_q == CNT_ONE),
      .rd_rdy   (Ready_i),
      .rd_vld   (fifo_vld),
      .rd_dat   (fifo_dat),
      .rd_last  (fifo_last),
      .count    (fifo_cnt)
   );

   assign RAM_REn_o  = issue;
   assign RAM_Addr_o = issue ? addr_q : addr_out_q;
   assign Valid_o    = fifo_vld;
   assign Data_o     = fifo_dat;
   assign Last_o     = fifo_vld & fifo_last;
   assign Busy_o     = (state_q != IDLE);
   assign Done_o     = done_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Directed bench for ram_stream_reader with a 1-cycle-latency RAM holding mem[i]=i[7:0].
// Samples 2 ns after each falling edge; inputs change on the falling edge before sampling.
module tb_ram_stream_reader;

   localparam int AW = 10;
   localparam int DW = 8;
   localparam int LW = AW + 1;

   logic          Clk_i = 1'b0;
   logic          RstN_i;
   logic          Start_i;
   logic [AW-1:0] BaseAddr_i;
   logic [LW-1:0] Len_i;
   logic          RAM_REn_o;
   logic [AW-1:0] RAM_Addr_o;
   logic [DW-1:0] RAM_Data_i;
   logic [DW-1:0] Data_o;
   logic          Valid_o;
   logic          Ready_i;
   logic          Last_o;
   logic          Busy_o;
   logic          Done_o;

   ram_stream_reader #(.DATAWIDTH(DW), .ADDRWIDTH(AW)) dut (
      .Clk_i      (Clk_i),
      .RstN_i     (RstN_i),
      .Start_i    (Start_i),
      .BaseAddr_i (BaseAddr_i),
      .Len_i      (Len_i),
      .RAM_REn_o  (RAM_REn_o),
      .RAM_Addr_o (RAM_Addr_o),
      .RAM_Data_i (RAM_Data_i),
      .Data_o     (Data_o),
      .Valid_o    (Valid_o),
      .Ready_i    (Ready_i),
      .Last_o     (Last_o),
      .Busy_o     (Busy_o),
      .Done_o     (Done_o)
   );

   always #5 Clk_i = ~Clk_i;

   logic [DW-1:0] mem [1024];
   logic [DW-1:0] ram_rdata = '0;
   initial for (int i = 0; i < 1024; i++) mem[i] = DW'(i);
   always @(posedge Clk_i) if (RAM_REn_o) ram_rdata <= mem[RAM_Addr_o];
   assign RAM_Data_i = ram_rdata;

   int cyc = 0;
   always @(posedge Clk_i) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;

   // observation log
   logic [DW-1:0] got_dat [$];
   logic          got_last [$];
   int            hs_cyc [$];
   int            done_cyc [$];
   int            rise_cyc [$];
   int            ren_cnt = 0;
   int            vld_cnt = 0;
   int            pending = 0;
   logic          prev_stall = 1'b0;
   logic          prev_vld = 1'b0;
   logic [DW-1:0] prev_dat = '0;
   logic          prev_last = 1'b0;
   int            start_cyc = 0;

   logic [DW-1:0] t2_exp [8] = '{8'd252, 8'd253, 8'd254, 8'd255, 8'd0, 8'd1, 8'd2, 8'd3};
   logic [DW-1:0] t6_exp [3] = '{8'd188, 8'd189, 8'd190};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic int qget(input int q[$], input int idx);
      if (idx < 0 || idx >= q.size()) return -1000;
      return q[idx];
   endfunction

   task automatic sample();
      logic hs;
      #2;
      if (!RstN_i) begin
         pending    = 0;
         prev_stall = 1'b0;
         prev_vld   = 1'b0;
      end else begin
         hs = Valid_o && Ready_i;
         if (prev_stall) begin
            chk("stall_hold_dat", 32'(Data_o), 32'(prev_dat));
            chk("stall_hold_last", 32'(Last_o), 32'(prev_last));
         end
         if (RAM_REn_o) begin
            chk("ren_pending_lt2", 32'((pending - int'(hs)) < 2), 32'd1);
            ren_cnt++;
         end
         pending = pending + int'(RAM_REn_o) - int'(hs);
         if (Valid_o) vld_cnt++;
         if (Valid_o && !prev_vld) rise_cyc.push_back(cyc);
         if (hs) begin
            got_dat.push_back(Data_o);
            got_last.push_back(Last_o);
            hs_cyc.push_back(cyc);
         end
         if (Done_o) begin
            done_cyc.push_back(cyc);
            chk("busy_low_at_done", 32'(Busy_o), 32'd0);
         end
         prev_stall = Valid_o && !Ready_i;
         prev_vld   = Valid_o;
         prev_dat   = Data_o;
         prev_last  = Last_o;
      end
   endtask

   task automatic cyc_end();
      sample();
      @(negedge Clk_i);
   endtask

   task automatic launch(input int base, input int len);
      Start_i    = 1'b1;
      BaseAddr_i = AW'(base);
      Len_i      = LW'(len);
      start_cyc  = cyc;
      cyc_end();
      Start_i = 1'b0;
      cyc_end();
   endtask

   task automatic wait_done(input string tag, input bit toggle, input int d0);
      int n = 0;
      while (done_cyc.size() == d0 && n < 400) begin
         if (toggle) Ready_i = ~Ready_i;
         cyc_end();
         n++;
      end
      Ready_i = 1'b1;
      chk({tag, "_timeout"}, 32'(n >= 400), 32'd0);
      repeat (4) cyc_end();
   endtask

   task automatic check_words(input string tag, input int q0, input logic [DW-1:0] exp[$]);
      chk({tag, "_count"}, 32'(got_dat.size() - q0), 32'(exp.size()));
      foreach (exp[i]) begin
         if (q0 + i < got_dat.size()) begin
            chk($sformatf("%s_dat%0d", tag, i), 32'(got_dat[q0+i]), 32'(exp[i]));
            chk($sformatf("%s_last%0d", tag, i), 32'(got_last[q0+i]), 32'(i == exp.size() - 1));
         end
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      chk({tag, "_ren"}, 32'(RAM_REn_o), 32'd0);
      chk({tag, "_vld"}, 32'(Valid_o), 32'd0);
      chk({tag, "_last"}, 32'(Last_o), 32'd0);
      chk({tag, "_busy"}, 32'(Busy_o), 32'd0);
      chk({tag, "_done"}, 32'(Done_o), 32'd0);
      chk({tag, "_data"}, 32'(Data_o), 32'd0);
      chk({tag, "_addr"}, 32'(RAM_Addr_o), 32'd0);
   endtask

   initial begin
      logic [DW-1:0] e [$];
      int q0, r0, v0, d0, s0, n;

      RstN_i = 1'b0; Start_i = 1'b0; BaseAddr_i = '0; Len_i = '0; Ready_i = 1'b1;
      @(negedge Clk_i);
      cyc_end();
      cyc_end();
      #3;
      check_zero_outputs("rst");
      @(negedge Clk_i);
      RstN_i = 1'b1;
      cyc_end();

      // burst of 16 from 0, full rate
      q0 = got_dat.size(); d0 = done_cyc.size(); s0 = rise_cyc.size();
      launch(0, 16);
      wait_done("t1", 1'b0, d0);
      e.delete();
      for (int i = 0; i < 16; i++) e.push_back(DW'(i));
      check_words("t1", q0, e);
      chk("t1_first_vld_lat", 32'(qget(rise_cyc, s0) - (start_cyc + 1)), 32'd2);
      chk("t1_back_to_back", 32'(qget(hs_cyc, q0 + 15) - qget(hs_cyc, q0)), 32'd15);
      chk("t1_done_lat", 32'(qget(done_cyc, d0) - qget(hs_cyc, q0 + 15)), 32'd1);
      chk("t1_done_cnt", 32'(done_cyc.size() - d0), 32'd1);

      // address wrap 1023 -> 0
      q0 = got_dat.size(); d0 = done_cyc.size();
      launch(1020, 8);
      wait_done("t2", 1'b0, d0);
      e.delete();
      foreach (t2_exp[i]) e.push_back(t2_exp[i]);
      check_words("t2", q0, e);
      chk("t2_done_cnt", 32'(done_cyc.size() - d0), 32'd1);

      // Ready toggling every cycle
      q0 = got_dat.size(); d0 = done_cyc.size(); r0 = ren_cnt;
      launch(100, 16);
      wait_done("t3", 1'b1, d0);
      e.delete();
      for (int i = 0; i < 16; i++) e.push_back(DW'(100 + i));
      check_words("t3", q0, e);
      chk("t3_ren_cnt", 32'(ren_cnt - r0), 32'd16);
      chk("t3_done_cnt", 32'(done_cyc.size() - d0), 32'd1);

      // zero-length burst
      q0 = got_dat.size(); d0 = done_cyc.size(); r0 = ren_cnt; v0 = vld_cnt;
      launch(33, 0);
      wait_done("t4", 1'b0, d0);
      chk("t4_ren_cnt", 32'(ren_cnt - r0), 32'd0);
      chk("t4_vld_cnt", 32'(vld_cnt - v0), 32'd0);
      chk("t4_done_lat", 32'(qget(done_cyc, d0) - start_cyc), 32'd1);
      chk("t4_done_cnt", 32'(done_cyc.size() - d0), 32'd1);

      // second Start while busy must be ignored
      q0 = got_dat.size(); d0 = done_cyc.size(); r0 = ren_cnt;
      Start_i = 1'b1; BaseAddr_i = AW'(40); Len_i = LW'(4); start_cyc = cyc;
      cyc_end();
      Start_i = 1'b0;
      cyc_end();
      Start_i = 1'b1; BaseAddr_i = AW'(500); Len_i = LW'(4);
      cyc_end();
      Start_i = 1'b0;
      wait_done("t5", 1'b0, d0);
      e.delete();
      for (int i = 0; i < 4; i++) e.push_back(DW'(40 + i));
      check_words("t5", q0, e);
      chk("t5_ren_cnt", 32'(ren_cnt - r0), 32'd4);
      chk("t5_done_cnt", 32'(done_cyc.size() - d0), 32'd1);

      // reset after 5 words of a 10-word burst
      q0 = got_dat.size(); d0 = done_cyc.size();
      launch(10, 10);
      n = 0;
      while (got_dat.size() - q0 < 5 && n < 100) begin
         cyc_end();
         n++;
      end
      chk("t6_wait_timeout", 32'(n >= 100), 32'd0);
      #1;
      RstN_i = 1'b0;
      #1;
      check_zero_outputs("t6_rst");
      chk("t6_pre_cnt", 32'(got_dat.size() - q0), 32'd5);
      for (int i = 0; i < 5; i++) begin
         if (q0 + i < got_dat.size())
            chk($sformatf("t6_pre_dat%0d", i), 32'(got_dat[q0+i]), 32'(10 + i));
      end
      @(negedge Clk_i);
      repeat (3) cyc_end();
      RstN_i = 1'b1;
      v0 = vld_cnt;
      repeat (4) cyc_end();
      chk("t6_no_done", 32'(done_cyc.size() - d0), 32'd0);
      chk("t6_quiet_vld", 32'(vld_cnt - v0), 32'd0);
      q0 = got_dat.size(); d0 = done_cyc.size();
      launch(700, 3);
      wait_done("t6b", 1'b0, d0);
      e.delete();
      foreach (t6_exp[i]) e.push_back(t6_exp[i]);
      check_words("t6b", q0, e);
      chk("t6b_done_cnt", 32'(done_cyc.size() - d0), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "bench time limit reached");
   end

endmodule
